// File: rtl/risc_control_fsm.sv
// rtl/risc_control_fsm.sv - multicycle control unit for the 16-bit RISC datapath
// Only the state is registered; every control output is decoded from state, IR and status inputs.
module risc_control_fsm (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [15:0] i_instr,
    input  logic       i_alu_zero,
    input  logic       i_flag_c,
    input  logic       i_flag_z,
    input  logic       i_mem_ready,
    output logic       o_ir_we,
    output logic       o_pc_we,
    output logic       o_a_we,
    output logic       o_b_we,
    output logic       o_t1_we,
    output logic       o_rf_we,
    output logic       o_c_we,
    output logic       o_z_we,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic       o_addr_sel,
    output logic [1:0] o_alu_a_sel,
    output logic [1:0] o_alu_b_sel,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_rf_wa_sel,
    output logic [1:0] o_rf_wd_sel,
    output logic [1:0] o_pc_sel,
    output logic       o_instr_done,
    output logic       o_halted,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC_R  = 4'd2,
        ST_EXEC_I  = 4'd3,
        ST_WB      = 4'd4,
        ST_LHI     = 4'd5,
        ST_ADDR    = 4'd6,
        ST_MEM_RD  = 4'd7,
        ST_MEM_WR  = 4'd8,
        ST_BR_CMP  = 4'd9,
        ST_BR_TAKE = 4'd10,
        ST_JUMP    = 4'd11,
        ST_HALT    = 4'd15
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NDU  = 4'b0010;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_JLR  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] HALT_OP = 4'hF;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_NAND = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_opcode;
    logic       w_cond_ok;

    assign w_opcode = i_instr[15:12];
    assign o_state  = r_state;

    // ADD/NDU predication: 00 always, 10 on carry, 01 on zero, 11 never.
    always_comb begin
        case (i_instr[1:0])
            2'b00:   w_cond_ok = 1'b1;
            2'b10:   w_cond_ok = i_flag_c;
            2'b01:   w_cond_ok = i_flag_z;
            default: w_cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_ir_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_a_we       = 1'b0;
        o_b_we       = 1'b0;
        o_t1_we      = 1'b0;
        o_rf_we      = 1'b0;
        o_c_we       = 1'b0;
        o_z_we       = 1'b0;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_addr_sel   = 1'b0;
        o_alu_a_sel  = 2'd0;
        o_alu_b_sel  = 2'd0;
        o_alu_op     = ALU_ADD;
        o_rf_wa_sel  = 2'd0;
        o_rf_wd_sel  = 2'd0;
        o_pc_sel     = 2'd0;
        o_instr_done = 1'b0;
        o_halted     = 1'b0;

        if (!i_reset) begin
            case (r_state)
                ST_FETCH: begin
                    o_mem_rd = 1'b1;
                    if (i_mem_ready) begin
                        o_ir_we     = 1'b1;
                        o_pc_we     = 1'b1;
                        o_alu_b_sel = 2'd1;
                        w_next      = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    o_a_we = 1'b1;
                    o_b_we = 1'b1;
                    case (w_opcode)
                        OP_ADD, OP_NDU: begin
                            if (w_cond_ok) begin
                                w_next = ST_EXEC_R;
                            end else begin
                                w_next       = ST_FETCH;
                                o_instr_done = 1'b1;
                            end
                        end
                        OP_ADI:         w_next = ST_EXEC_I;
                        OP_LHI:         w_next = ST_LHI;
                        OP_LW, OP_SW:   w_next = ST_ADDR;
                        OP_BEQ:         w_next = ST_BR_CMP;
                        OP_JAL, OP_JLR: w_next = ST_JUMP;
                        HALT_OP:        w_next = ST_HALT;
                        default: begin
                            w_next       = ST_FETCH;
                            o_instr_done = 1'b1;
                        end
                    endcase
                end
                ST_EXEC_R: begin
                    o_alu_a_sel = 2'd1;
                    o_t1_we     = 1'b1;
                    o_z_we      = 1'b1;
                    if (w_opcode == OP_NDU) begin
                        o_alu_op = ALU_NAND;
                    end else begin
                        o_c_we = 1'b1;
                    end
                    w_next = ST_WB;
                end
                ST_EXEC_I: begin
                    o_alu_a_sel = 2'd1;
                    o_alu_b_sel = 2'd2;
                    o_t1_we     = 1'b1;
                    o_c_we      = 1'b1;
                    o_z_we      = 1'b1;
                    w_next      = ST_WB;
                end
                ST_WB: begin
                    o_rf_we      = 1'b1;
                    o_rf_wa_sel  = (w_opcode == OP_ADI) ? 2'd1 : 2'd0;
                    o_instr_done = 1'b1;
                    w_next       = ST_FETCH;
                end
                ST_LHI: begin
                    o_rf_we      = 1'b1;
                    o_rf_wd_sel  = 2'd2;
                    o_rf_wa_sel  = 2'd2;
                    o_instr_done = 1'b1;
                    w_next       = ST_FETCH;
                end
                ST_ADDR: begin
                    o_alu_a_sel = 2'd2;
                    o_alu_b_sel = 2'd2;
                    o_t1_we     = 1'b1;
                    w_next      = (w_opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    o_mem_rd   = 1'b1;
                    o_addr_sel = 1'b1;
                    if (i_mem_ready) begin
                        o_rf_we      = 1'b1;
                        o_rf_wd_sel  = 2'd1;
                        o_rf_wa_sel  = 2'd2;
                        o_instr_done = 1'b1;
                        w_next       = ST_FETCH;
                    end
                end
                ST_MEM_WR: begin
                    o_mem_wr   = 1'b1;
                    o_addr_sel = 1'b1;
                    if (i_mem_ready) begin
                        o_instr_done = 1'b1;
                        w_next       = ST_FETCH;
                    end
                end
                ST_BR_CMP: begin
                    o_alu_a_sel = 2'd1;
                    o_alu_op    = ALU_SUB;
                    if (i_alu_zero) begin
                        w_next = ST_BR_TAKE;
                    end else begin
                        o_instr_done = 1'b1;
                        w_next       = ST_FETCH;
                    end
                end
                ST_BR_TAKE: begin
                    // PC already points past the branch, so the offset is relative to PC+1.
                    o_alu_b_sel  = 2'd2;
                    o_pc_we      = 1'b1;
                    o_instr_done = 1'b1;
                    w_next       = ST_FETCH;
                end
                ST_JUMP: begin
                    o_rf_we     = 1'b1;
                    o_rf_wd_sel = 2'd3;
                    o_rf_wa_sel = 2'd2;
                    o_pc_we     = 1'b1;
                    if (w_opcode == OP_JLR) begin
                        o_pc_sel = 2'd2;
                    end else begin
                        o_alu_b_sel = 2'd3;
                    end
                    o_instr_done = 1'b1;
                    w_next       = ST_FETCH;
                end
                ST_HALT: begin
                    o_halted = 1'b1;
                end
                default: begin
                    w_next = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/risc_control_fsm.md
# risc_control_fsm

Multicycle control unit for the 16-bit RISC datapath. It sequences the register file, ALU, memory, IR, T1 and A/B operand registers through fetch, decode, execute, memory and write-back. Every datapath write-enable, mux select and ALU opcode comes from this block. It sits beside the datapath and observes only the IR contents, ALU zero, the flag registers and the memory ready handshake.

## Interface
- HALT_OP, 4'hF: opcode that parks the controller in HALT.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; state returns to FETCH.
- instr  in  16  IR output; opcode is instr[15:12].
- alu_zero  in  1  combinational ALU zero of the current cycle.
- flag_c, flag_z  in  1 each  registered carry and zero flags.
- mem_ready  in  1  memory completes the current read or write this cycle.
- ir_we, pc_we, a_we, b_we, t1_we, rf_we  out  1 each  register write enables.
- c_we, z_we  out  1 each  flag write enables.
- mem_rd, mem_wr  out  1 each  memory strobes.
- addr_sel  out  1  memory address: 0 = PC, 1 = T1.
- alu_a_sel  out  2  ALU input A: 0 = PC, 1 = A, 2 = B.
- alu_b_sel  out  2  ALU input B: 0 = B, 1 = const 1, 2 = SE6(instr[5:0]), 3 = SE9(instr[8:0]).
- alu_op  out  2  0 = add, 1 = nand, 2 = sub.
- rf_wa_sel  out  2  write address: 0 = instr[5:3], 1 = instr[8:6], 2 = instr[11:9].
- rf_wd_sel  out  2  write data: 0 = T1, 1 = memory data, 2 = {instr[8:0], 7'b0}, 3 = PC.
- pc_sel  out  2  PC input: 0 = ALU out, 2 = B.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- halted  out  1  high while in HALT.
- state  out  4  current state, for debug.

## Operation
- Opcodes: ADD 0000, ADI 0001, NDU 0010, LHI 0011, LW 0100, SW 0101, JAL 1000, JLR 1001, BEQ 1100, HALT_OP.
- Any other opcode behaves as a NOP: DECODE goes to FETCH with instr_done.
- ADD/NDU condition, from instr[1:0]: 00 always; 10 only if flag_c; 01 only if flag_z; 11 never.
- State encoding: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, WB 4, LHI 5, ADDR 6, MEM_RD 7, MEM_WR 8, BR_CMP 9, BR_TAKE 10, JUMP 11, HALT 15.
- FETCH
  - Drives mem_rd=1, addr_sel=0.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: ir_we, pc_we, PC+1 (a_sel 0, b_sel 1, add), then go to DECODE.
- DECODE: a_we, b_we, then dispatch:
  - ADD/NDU with condition true → EXEC_R; condition false → FETCH with instr_done.
  - ADI → EXEC_I; LHI → LHI; LW/SW → ADDR; BEQ → BR_CMP; JAL/JLR → JUMP; HALT_OP → HALT.
- EXEC_R: A op B into T1, t1_we.
  - ADD also asserts c_we and z_we; NDU asserts z_we only.
  - Next: WB.
- EXEC_I: A + SE6 into T1; t1_we, c_we, z_we; next WB.
- WB: rf_we, rf_wd_sel=0. rf_wa_sel=0 for ADD/NDU, 1 for ADI. Next FETCH, with instr_done.
- LHI: rf_we, rf_wd_sel=2, rf_wa_sel=2; next FETCH, with instr_done.
- ADDR: B + SE6 into T1, t1_we; next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD
  - Drives mem_rd, addr_sel=1.
  - Waits while mem_ready=0.
  - When mem_ready=1: rf_we, rf_wd_sel=1, rf_wa_sel=2, then FETCH with instr_done.
- MEM_WR: mem_wr, addr_sel=1 (store data is A). Waits while mem_ready=0; when mem_ready=1 goes to FETCH with instr_done.
- BR_CMP: A sub B, no flag writes.
  - alu_zero=1 → BR_TAKE.
  - alu_zero=0 → FETCH with instr_done.
- BR_TAKE: PC + SE6 (offset relative to the incremented PC), pc_we; next FETCH, with instr_done.
- JUMP
  - Link: rf_we, rf_wd_sel=3, rf_wa_sel=2. The link value is the already-incremented PC.
  - Same cycle, pc_we: JAL uses pc_sel 0 with PC + SE9; JLR uses pc_sel 2.
  - Next FETCH, with instr_done.
- HALT: all enables 0, halted=1; leaves only on reset.

## Timing
- Outputs are combinational from state, instr, mem_ready, alu_zero and flags. Only state is registered.
- Any signal not listed for a state is 0. instr_done is asserted only in the cycle whose next state is FETCH.
- Reset
  - While reset=1, every enable, strobe and instr_done is forced to 0, select outputs read 0, and halted=0.
  - The next state is FETCH.
- Reset mid-memory: the strobe drops in the reset cycle; no partial write-back occurs.
- Cycle counts with zero memory wait:
  - ADD/NDU/ADI 4; LW/SW 4.
  - LHI 3; JAL/JLR 3.
  - BEQ 3 not taken, 4 taken.
  - Skipped conditional 2.
- Each memory wait cycle adds one cycle.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Flag writes occur only in EXEC_R/EXEC_I; skipped instructions touch no flags and no registers.

## Test plan
- Reset with mem_ready=1, then ADD r3=r1+r2 (instr 16'h0298) → state sequence 0,1,2,4,0; rf_we only in WB with rf_wa_sel=0; instr_done once, 4 cycles after FETCH entry.
- LW with mem_ready low for 3 cycles in MEM_RD → mem_rd held 4 cycles with addr_sel=1; rf_we only in the ready cycle; total 7 cycles.
- ADD with instr[1:0]=10 and flag_c=0 → DECODE→FETCH; no c_we, z_we, t1_we or rf_we; instr_done in DECODE.
- BEQ with alu_zero=1, then BEQ with alu_zero=0 → 4 cycles with pc_we in BR_TAKE (b_sel=2); then 3 cycles with no pc_we after FETCH.
- JLR → in JUMP, rf_we with rf_wd_sel=3 and pc_we with pc_sel=2 in the same cycle.
- Opcode 4'hF → halted=1 and all enables 0 indefinitely; reset asserted in the middle of an SW wait → mem_wr=0 in the reset cycle, state=FETCH next.
